// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode encodings, FSM states and op classification for alu_seq (DIV iterative only with ALU_DIV_EN)
package alu_seq_pkg;
  localparam int OP_LDW  = 0;
  localparam int OP_SDW  = 1;
  localparam int OP_ADD  = 2;
  localparam int OP_SUB  = 3;
  localparam int OP_BEQ  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLT  = 8;
  localparam int OP_JUMP = 9;
  localparam int OP_MUL  = 10;
  localparam int OP_DIV  = 11;
  typedef enum logic {ALU_IDLE, ALU_ITER} state_t;
  function automatic logic is_iter_op(input int op);
`ifdef ALU_DIV_EN
    return op == OP_MUL || op == OP_DIV;
`else
    return op == OP_MUL;
`endif
  endfunction
endpackage

// File: rtl/alu_iter.sv
// alu_iter: WIDTH-step radix-2 shift-add multiplier, plus restoring divider on one shared adder when ALU_DIV_EN
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH);
  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_r, lo_r, b_r;
  assign done = busy && cnt == CW'(WIDTH - 1);
`ifdef ALU_DIV_EN
  logic             div_r, ge;
  logic [WIDTH+1:0] lhs, rhs, sum;
  // divide subtracts the divisor from {rem,next dividend bit}; multiply adds b when the multiplier lsb is set
  always_comb begin
    lhs = div_r ? {1'b0, hi_r, lo_r[WIDTH-1]} : {2'b0, hi_r};
    rhs = div_r ? ~{2'b0, b_r} : {2'b0, b_r & {WIDTH{lo_r[0]}}};
    sum = lhs + rhs + (WIDTH+2)'(div_r);
    ge  = !sum[WIDTH+1];
    hi  = div_r ? (ge ? sum[WIDTH-1:0] : {hi_r[WIDTH-2:0], lo_r[WIDTH-1]}) : sum[WIDTH:1];
    lo  = div_r ? {lo_r[WIDTH-2:0], ge} : {sum[0], lo_r[WIDTH-1:1]};
  end
`else
  logic             unused_op;
  logic [WIDTH:0]   sum;
  assign unused_op = op;
  always_comb begin
    sum = {1'b0, hi_r} + {1'b0, b_r & {WIDTH{lo_r[0]}}};
    hi  = sum[WIDTH:1];
    lo  = {sum[0], lo_r[WIDTH-1:1]};
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      hi_r <= '0;
      lo_r <= '0;
      b_r  <= '0;
`ifdef ALU_DIV_EN
      div_r <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      hi_r <= '0;
      lo_r <= a;
      b_r  <= b;
`ifdef ALU_DIV_EN
      div_r <= op;
`endif
    end else if (busy) begin
      hi_r <= hi;
      lo_r <= lo;
      cnt  <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle base ops and iterative MUL (DIV too when ALU_DIV_EN is defined)
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             zf,
  output logic             ovf
);
  state_t           state;
  logic             acc, it_op, it_done, div_z, res_ovf;
  logic [WIDTH-1:0] it_lo, it_hi, res, nb, sum, dif;
  assign in_ready = !rst && state == ALU_IDLE && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign it_op    = is_iter_op(int'(opcode));
  assign nb       = ~b + WIDTH'(1);
  assign sum      = a + b;
  assign dif      = a + nb;
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (opcode)
      OPW'(OP_LDW), OPW'(OP_SDW): res = sum;
      OPW'(OP_ADD): begin
        res     = sum;
        res_ovf = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      OPW'(OP_SUB): begin
        res     = dif;
        res_ovf = a[WIDTH-1] == nb[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1];
      end
      OPW'(OP_BEQ):  res = dif;
      OPW'(OP_AND):  res = a & b;
      OPW'(OP_OR):   res = a | b;
      OPW'(OP_XOR):  res = a ^ b;
      OPW'(OP_SLT):  res = WIDTH'($signed(a) < $signed(b));
      OPW'(OP_JUMP): res = a;
      default:       res = '0;
    endcase
  end
  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk  (clk),
    .rst  (rst),
    .start(acc && it_op),
    .op   (opcode == OPW'(OP_DIV)),
    .a    (a),
    .b    (b),
    .done (it_done),
    .lo   (it_lo),
    .hi   (it_hi)
  );
`ifdef ALU_DIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_z <= 1'b0;
    else if (acc && it_op) div_z <= opcode == OPW'(OP_DIV) && b == '0;
  end
`else
  assign div_z = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ALU_IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      alu_hi    <= '0;
      zf        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (acc && it_op) state <= ALU_ITER;
      else if (acc) begin
        out_valid <= 1'b1;
        alu_out   <= res;
        alu_hi    <= '0;
        zf        <= res == '0;
        ovf       <= res_ovf;
      end
      if (state == ALU_ITER && it_done) begin
        state     <= ALU_IDLE;
        out_valid <= 1'b1;
        alu_out   <= it_lo;
        alu_hi    <= it_hi;
        zf        <= it_lo == '0;
        ovf       <= div_z;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors against a behavioural model of alu_seq (DIV paths follow ALU_DIV_EN)
module tb_alu_seq;
  import alu_seq_pkg::*;
  localparam int W = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [5:0]   opcode = '0;
  logic         in_ready, out_valid, zf, ovf;
  logic [W-1:0] alu_out, alu_hi;
  int pass_n = 0, total_n = 0;
  alu_seq #(.WIDTH(W), .OPW(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .alu_hi(alu_hi), .zf(zf), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask
  function automatic logic is_iter(input int op);
    return op == OP_MUL || (DIV_EN && op == OP_DIV);
  endfunction
  // returns {ovf, hi, lo} computed from plain arithmetic
  function automatic logic [64:0] calc(input int op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    longint s;
    logic [63:0] p;
    case (op)
      OP_LDW, OP_SDW: return {33'd0, x + y};
      OP_ADD: begin
        r = x + y;
        s = longint'($signed(x)) + longint'($signed(y));
        return {s != longint'($signed(r)), 32'd0, r};
      end
      OP_SUB: begin
        r = x - y;
        s = longint'($signed(x)) - longint'($signed(y));
        return {s != longint'($signed(r)), 32'd0, r};
      end
      OP_BEQ:  return {33'd0, x - y};
      OP_AND:  return {33'd0, x & y};
      OP_OR:   return {33'd0, x | y};
      OP_XOR:  return {33'd0, x ^ y};
      OP_SLT:  return {33'd0, 32'($signed(x) < $signed(y))};
      OP_JUMP: return {33'd0, x};
      OP_MUL: begin
        p = 64'(x) * 64'(y);
        return {1'b0, p};
      end
      OP_DIV: begin
        if (!DIV_EN) return '0;
        if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
        return {1'b0, x % y, x / y};
      end
      default: return '0;
    endcase
  endfunction
  logic        m_valid, m_ovf, m_acc;
  logic [31:0] m_out, m_hi;
  logic [64:0] pend;
  int          m_left;
  wire m_ready = !rst && m_left == 0 && (!m_valid || out_ready);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_out = '0; m_hi = '0; m_ovf = 1'b0; m_left = 0;
    end else begin
      m_acc = in_valid && m_ready;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1'b1;
          {m_ovf, m_hi, m_out} = pend;
        end
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_acc && is_iter(int'(opcode))) begin
          pend   = calc(int'(opcode), a, b);
          m_left = W;
        end else if (m_acc) begin
          m_valid = 1'b1;
          {m_ovf, m_hi, m_out} = calc(int'(opcode), a, b);
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("alu_out", alu_out, m_out);
      chk("alu_hi", alu_hi, m_hi);
      chk("zf", zf, m_out == 0);
      chk("ovf", ovf, m_ovf);
    end
  end
  task automatic send(input int op, input logic [31:0] x, input logic [31:0] y);
    opcode = 6'(op); a = x; b = y; in_valid = 1'b1;
    for (int t = 0; t < 100 && !in_ready; t++) @(negedge clk);
    if (!in_ready) begin
      total_n++;
      $display("FAIL accept_timeout op %0d: got in_ready 0 want 1", op);
    end else @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_busy(output int n);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  typedef struct {int op; logic [31:0] x, y, e;} vec_t;
  vec_t tv[9] = '{
    '{OP_AND, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030},
    '{OP_OR, 32'h0F0000F0, 32'h00000F0F, 32'h0F000FFF},
    '{OP_JUMP, 32'h12345678, 32'h0, 32'h12345678},
    '{OP_LDW, 32'd10, 32'd20, 32'd30},
    '{OP_BEQ, 32'd3, 32'd5, 32'hFFFFFFFE},
    '{OP_SDW, 32'hFFFFFFFF, 32'd1, 32'h0},
    '{OP_SLT, 32'd1, 32'hFFFFFFFF, 32'h0},
    '{63, 32'd5, 32'd6, 32'h0},
    '{OP_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF}
  };
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_alu_hi", alu_hi, 0);
    chk("rst_zf", zf, 0);
    chk("rst_in_ready", in_ready, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    send(OP_ADD, 32'h7FFFFFFF, 32'd1);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_out", alu_out, 32'h80000000);
    chk("add_ovf", ovf, 1);
    chk("add_zf", zf, 0);
    send(OP_SUB, 32'd5, 32'd5);
    @(negedge clk);
    chk("sub_out", alu_out, 0);
    chk("sub_zf", zf, 1);
    send(OP_SLT, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    chk("slt_out", alu_out, 1);
    foreach (tv[i]) begin
      send(tv[i].op, tv[i].x, tv[i].y);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), alu_out, tv[i].e);
    end
    send(OP_MUL, 32'hFFFFFFFF, 32'd2);
    wait_busy(n);
    chk("mul_busy_cycles", n, W);
    chk("mul_valid", out_valid, 1);
    chk("mul_hi", alu_hi, 1);
    chk("mul_lo", alu_out, 32'hFFFFFFFE);
    send(OP_MUL, 32'h12345678, 32'h9ABCDEF0);
    wait_busy(n);
    send(OP_ADD, 32'd3, 32'd4);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_out", alu_out, 7);
    chk("hold_valid", out_valid, 1);
    chk("hold_ready", in_ready, 0);
    out_ready = 1'b1;
    send(OP_XOR, 32'h0000F0F0, 32'h0000FF00);
    @(negedge clk);
    chk("xor_out", alu_out, 32'h00000FF0);
    send(OP_MUL, 32'd6, 32'd7);
    @(negedge clk);
    chk("mul_drain_valid", out_valid, 0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("midrst_out", alu_out, 0);
    chk("midrst_valid", out_valid, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("midrst_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    send(OP_ADD, 32'd1, 32'd1);
    @(negedge clk);
    chk("after_rst_add", alu_out, 2);
`ifdef ALU_DIV_EN
    send(OP_DIV, 32'd100, 32'd7);
    wait_busy(n);
    chk("div_busy_cycles", n, W);
    chk("div_q", alu_out, 14);
    chk("div_r", alu_hi, 2);
    chk("div_ovf", ovf, 0);
    send(OP_DIV, 32'd9, 32'd0);
    wait_busy(n);
    chk("div0_busy_cycles", n, W);
    chk("div0_q", alu_out, 32'hFFFFFFFF);
    chk("div0_r", alu_hi, 9);
    chk("div0_ovf", ovf, 1);
`else
    send(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    chk("nodiv_valid", out_valid, 1);
    chk("nodiv_out", alu_out, 0);
    chk("nodiv_hi", alu_hi, 0);
    chk("nodiv_zf", zf, 1);
`endif
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
